dword_add_seq: RTL and testbench
================================

DWORD_ADD_SEQ -- requirements
Module: dword_add_seq

Interface
REQ-001 Parameter: none; width fixed at 32-bit operands, 16-bit datapath half.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled on rising clk edge.
REQ-005 sub  input  1  1 = A-B, 0 = A+B; present only with SUB_EN.
REQ-006 a  input  32  operand A, sampled only when start is accepted.
REQ-007 b  input  32  operand B, sampled only when start is accepted.
REQ-008 busy  output  1  operation in progress (LOW or HIGH state).
REQ-009 done  output  1  one-cycle completion pulse (DONE state).
REQ-010 result  output  32  registered sum/difference.
REQ-011 cout  output  1  carry out of bit 31; for subtract, 1 = no borrow.
REQ-012 overflow  output  1  signed two's-complement overflow of the 32-bit operation.

Function
REQ-013 The block SHALL implement the FSM states IDLE, LOW, HIGH and DONE, sharing one 16-bit CLA across two cycles.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL latch a, b and sub, and move to LOW; otherwise IDLE stays IDLE and DONE goes to IDLE.
REQ-015 LOW SHALL add a[15:0] to b'[15:0] with carry-in = sub, register result[15:0] and the carry, and go to HIGH.
REQ-016 b' SHALL be ~b when sub=1 and b when sub=0.
REQ-017 HIGH SHALL add a[31:16] to b'[31:16] with the registered carry, register result[31:16], cout and overflow, and go to DONE.
REQ-018 Overflow SHALL be (a31==b'31) && (result31!=a31), evaluated on the latched operands.
REQ-019 Latency SHALL be fixed: start accepted at edge N gives done=1 for exactly the cycle following edge N+2.
REQ-020 start asserted in LOW or HIGH SHALL be ignored, with no queuing and no corruption of latched operands.
REQ-021 start in DONE SHALL be accepted back-to-back: done stays a single-cycle pulse and busy rises the next cycle.
REQ-022 result, cout and overflow SHALL hold their last completed values until the next HIGH state; result[15:0] SHALL update in LOW.
REQ-023 busy and done SHALL never be high together.

Reset
REQ-024 rst_n=0 SHALL immediately force the IDLE state and busy=0, done=0, result=0, cout=0 and overflow=0, including mid-operation.
REQ-025 An operation interrupted by reset SHALL be discarded and SHALL never produce done.

Configuration
REQ-026 With SUB_EN defined, the sub port SHALL exist and subtraction SHALL operate per REQ-015/016.
REQ-027 Without SUB_EN, the sub port SHALL be absent, and the block SHALL behave as if sub=0 (add only).

Structure
REQ-028 The shared package dword_add_pkg SHALL hold the state enum (IDLE, LOW, HIGH, DONE) and the constants DWORD_W=32 and HALF_W=16.
REQ-029 The 16-bit addition SHALL be a single instance of the existing word_CLA (A, B, CIn, Sum, COut, Overflow), muxed between halves by state.
REQ-030 The word_CLA Overflow output SHALL be used only in HIGH.

Verification
REQ-031 Add 0x0000FFFF+0x00000001 -> result 0x00010000, cout 0, overflow 0, done exactly 3 edges after start.
REQ-032 Add 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1, cout 0.
REQ-033 Add 0xFFFFFFFF+0x00000001 -> result 0x00000000, cout 1, overflow 0.
REQ-034 (SUB_EN) 0x00000000-0x00000001 -> result 0xFFFFFFFF, cout 0; 0x80000000-0x00000001 -> result 0x7FFFFFFF, overflow 1.
REQ-035 Start pulsed in LOW with different operands -> ignored, and the first result is reported. Start held through DONE -> second operation completes 3 edges later.
REQ-036 rst_n low during HIGH -> all outputs 0 and state IDLE; no done pulse follows release.

Source files
------------

// File: rtl/dword_add_pkg.sv
// dword_add_pkg: shared widths and FSM state encoding for the sequential dword adder
package dword_add_pkg;
  localparam int DWORD_W = 32;
  localparam int HALF_W  = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/word_CLA.sv
// word_CLA: 16-bit carry-lookahead adder (parallel-prefix carries) with carry and signed overflow out
module word_CLA
  import dword_add_pkg::*;
(
  input  logic [HALF_W-1:0] A,
  input  logic [HALF_W-1:0] B,
  input  logic              CIn,
  output logic [HALF_W-1:0] Sum,
  output logic              COut,
  output logic              Overflow
);
  logic [HALF_W-1:0] w_x, w_g, w_p;
  logic [HALF_W:0]   w_c;
  assign w_x = A ^ B;
  // in-place prefix: descending i reads lower bits before they are updated
  always_comb begin
    w_g = A & B;
    w_p = w_x;
    for (int s = 1; s < HALF_W; s = s * 2)
      for (int i = HALF_W - 1; i >= s; i--) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i-s]);
        w_p[i] = w_p[i] & w_p[i-s];
      end
  end
  assign w_c      = {w_g | (w_p & {HALF_W{CIn}}), CIn};
  assign Sum      = w_x ^ w_c[HALF_W-1:0];
  assign COut     = w_c[HALF_W];
  assign Overflow = w_c[HALF_W] ^ w_c[HALF_W-1];
endmodule

// File: rtl/dword_add_seq.sv
// dword_add_seq: 32-bit add/subtract over two cycles sharing one 16-bit CLA
// SUB_EN adds the sub port; without it the block only adds
module dword_add_seq
  import dword_add_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SUB_EN
  input  logic               sub,
`endif
  input  logic [DWORD_W-1:0] a,
  input  logic [DWORD_W-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [DWORD_W-1:0] result,
  output logic               cout,
  output logic               overflow
);
  state_t             r_state, w_next;
  logic [DWORD_W-1:0] r_a, r_b, r_result;
  logic               r_sub, r_carry, r_cout, r_ovf;
  logic               w_sub, w_accept, w_lo, w_hi;
  logic [HALF_W-1:0]  w_op_a, w_op_b, w_sum;
  logic               w_ci, w_co, w_ov;
`ifdef SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_lo     = r_state == LOW;
  assign w_hi     = r_state == HIGH;
  assign w_op_a   = w_hi ? r_a[DWORD_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_op_b   = w_hi ? r_b[DWORD_W-1:HALF_W] : r_b[HALF_W-1:0];
  assign w_ci     = w_hi ? r_carry : r_sub;
  word_CLA u_cla (
    .A       (w_op_a),
    .B       (w_op_b),
    .CIn     (w_ci),
    .Sum     (w_sum),
    .COut    (w_co),
    .Overflow(w_ov)
  );
  always_comb w_next = w_accept ? LOW : w_lo ? HIGH : w_hi ? DONE : IDLE;
  // r_b holds b already inverted for subtract, so the CLA only ever adds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= w_sub ? ~b : b;
        r_sub <= w_sub;
      end
      if (w_lo) begin
        r_result[HALF_W-1:0] <= w_sum;
        r_carry              <= w_co;
      end
      if (w_hi) begin
        r_result[DWORD_W-1:HALF_W] <= w_sum;
        r_cout                     <= w_co;
        r_ovf                      <= w_ov;
      end
    end
  assign busy     = w_lo || w_hi;
  assign done     = r_state == DONE;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_dword_add_seq.sv
// tb_dword_add_seq: scoreboard bench for dword_add_seq; SUB_EN enables subtract stimulus
module tb_dword_add_seq;
  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    int          t;
  } exp_t;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, overflow;
  logic [31:0] result;
`ifdef SUB_EN
  logic        sub = 1'b0;
`endif
  exp_t q[$];
  int   cyc = 0, last_drive = -100, dones = 0, n_chk = 0, n_pass = 0;
  dword_add_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef SUB_EN
    .sub     (sub),
`endif
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
  endtask
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input int t);
    exp_t        e;
    longint      r;
    logic [32:0] u;
    r   = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
    u   = {1'b0, x} + {1'b0, y};
    e.r = r[31:0];
    e.c = s ? (x >= y) : u[32];
    e.v = (r > MAXS) || (r < MINS);
    e.t = t;
    return e;
  endfunction
  // a start is taken only if three cycles have passed since the last taken one
  task automatic drive(input logic st, input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    @(posedge clk);
    #1;
    start = st;
    a     = ta;
    b     = tb;
`ifdef SUB_EN
    sub   = ts;
`endif
    if (st && cyc >= last_drive + 3) begin
      q.push_back(model(ta, tb, ts, cyc + 3));
      last_drive = cyc;
    end
  endtask
  always @(negedge clk)
    if (rst_n && done) begin
      exp_t e;
      dones++;
      chk("busy_with_done", {63'd0, busy}, 64'd0);
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("result", {32'd0, result}, {32'd0, e.r});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
        chk("overflow", {63'd0, overflow}, {63'd0, e.v});
        chk("latency", longint'(cyc), longint'(e.t));
      end
    end
  initial begin
    logic s;
    int   d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_out", {31'd0, result, cout, overflow}, 64'd0);
    rst_n = 1'b1;
    drive(1, 32'h0000FFFF, 32'h00000001, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 32'h7FFFFFFF, 32'h00000001, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 32'hFFFFFFFF, 32'h00000001, 0);
    drive(1, 32'h12345678, 32'h11111111, 0);
    drive(0, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    drive(1, 32'hA5A5A5A5, 32'h5A5A5A5B, 0);
    drive(1, 32'h80000000, 32'h80000000, 0);
    drive(1, 32'h80000000, 32'h80000000, 0);
    drive(1, 32'h80000000, 32'h80000000, 0);
    drive(0, 0, 0, 0);
`ifdef SUB_EN
    drive(1, 32'h00000000, 32'h00000001, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 32'h80000000, 32'h00000001, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 32'h00000005, 32'h00000005, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
`endif
    for (int n = 0; n < 40; n++) begin
`ifdef SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      drive(1, $urandom, $urandom, s);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)) & s);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)) & s);
      repeat ($urandom_range(0, 2)) drive(0, $urandom, $urandom, 0);
    end
    repeat (4) drive(0, 0, 0, 0);
    chk("queue_before_reset", longint'(q.size()), 64'd0);
    drive(1, 32'h13572468, 32'h24681357, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_out", {31'd0, result, cout, overflow}, 64'd0);
    q.delete();
    last_drive = -100;
    d0 = dones;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) drive(0, 0, 0, 0);
    chk("no_done_after_reset", longint'(dones - d0), 64'd0);
    chk("idle_after_reset", {63'd0, busy}, 64'd0);
    drive(1, 32'h0000FFFF, 32'h00000001, 0);
    repeat (8) drive(0, 0, 0, 0);
    chk("queue_drained", longint'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
